// File: rtl/instruction_sequencer_pkg.sv
// seq_pkg: opcodes, FSM states, opcode classes and instruction field positions for instruction_sequencer
package seq_pkg;
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_OUT  = 3'b100;
  localparam logic [2:0] OP_LDI  = 3'b101;
  localparam logic [2:0] OP_MV   = 3'b111;
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int RX_MSB  = 12;
  localparam int RX_LSB  = 10;
  localparam int RY_MSB  = 9;
  localparam int RY_LSB  = 7;
  localparam int IMM_MSB = 9;
  localparam int IMM_LSB = 0;
  typedef enum logic [2:0] {IDLE, FETCH, EX1, EX2, EX3, HALT} state_t;
  typedef struct packed {
    logic alu;
    logic move;
    logic imm;
    logic outp;
    logic illegal;
  } cls_t;
endpackage

// File: rtl/instruction_sequencer_if.sv
// seq_if: instruction fetch and datapath control bundle between memory, sequencer and datapath
interface seq_if #(parameter int NREGS = 8);
  logic             Run;
  logic [15:0]      iin;
  logic             IRin;
  logic [NREGS-1:0] Rin;
  logic [NREGS-1:0] Rout;
  logic             Ain;
  logic             Gin;
  logic             Gout;
  logic             DINout;
  logic [15:0]      DinData;
  logic [2:0]       AluOp;
  logic             OutEn;
  logic [1:0]       Step;
  logic             Clear;
  logic             Done;
  logic             Illegal;
  modport master (output Run, iin, input IRin, Rin, Rout, Ain, Gin, Gout, DINout, DinData, AluOp, OutEn, Step, Clear, Done, Illegal);
  modport slave (input Run, iin, output IRin, Rin, Rout, Ain, Gin, Gout, DINout, DinData, AluOp, OutEn, Step, Clear, Done, Illegal);
endinterface

// File: rtl/instruction_sequencer_decode.sv
// instr_decode: maps IR and FSM state to one-hot register enables and an opcode class
module instr_decode
  import seq_pkg::*;
#(
  parameter int NREGS = 8
) (
  input  logic [15:0]      ir,
  input  state_t           state,
  output logic [NREGS-1:0] rin,
  output logic [NREGS-1:0] rout,
  output cls_t             cls
);
  logic [2:0]       op;
  logic [NREGS-1:0] rx_oh;
  logic [NREGS-1:0] ry_oh;
  assign op    = ir[OP_MSB:OP_LSB];
  assign rx_oh = NREGS'(1) << ir[RX_MSB:RX_LSB];
  assign ry_oh = NREGS'(1) << ir[RY_MSB:RY_LSB];
  // classify the opcode, then pick which register drives and which loads in this step
  always_comb begin
    cls.alu     = op == OP_ADD || op == OP_SUB || op == OP_NAND;
    cls.move    = op == OP_MV;
    cls.imm     = op == OP_LDI;
    cls.outp    = op == OP_OUT;
    cls.illegal = !(cls.alu || cls.move || cls.imm || cls.outp);
    rout = state == EX2 ? ry_oh :
           state == EX1 && cls.move ? ry_oh :
           state == EX1 && (cls.alu || cls.outp) ? rx_oh : '0;
    rin  = state == EX3 || (state == EX1 && (cls.move || cls.imm)) ? rx_oh : '0;
  end
endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: multi-cycle control FSM with IR; SEQ_ILLEGAL_TRAP_EN makes illegal opcodes halt
module instruction_sequencer
  import seq_pkg::*;
#(
  parameter int NREGS = 8
) (
  input logic  Clock,
  input logic  Resetn,
  seq_if.slave bus
);
`ifdef SEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  state_t           state;
  state_t           next;
  logic [15:0]      ir;
  logic [NREGS-1:0] rin;
  logic [NREGS-1:0] rout;
  cls_t             cls;
  logic             ex1;
  instr_decode #(.NREGS(NREGS)) u_dec (
    .ir   (ir),
    .state(state),
    .rin  (rin),
    .rout (rout),
    .cls  (cls)
  );
  assign ex1 = state == EX1;
  // state register; reset abandons any partial instruction
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else state <= next;
  end
  // instruction register captures the word presented during FETCH
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) ir <= '0;
    else if (state == FETCH) ir <= bus.iin;
  end
  // step sequencing; Run only matters in IDLE and HALT is left only by reset
  always_comb begin
    next = state == IDLE  ? (bus.Run ? FETCH : IDLE) :
           state == FETCH ? EX1 :
           state == EX1   ? (cls.alu ? EX2 : (cls.illegal && TRAP) ? HALT : IDLE) :
           state == EX2   ? EX3 :
           state == HALT  ? HALT : IDLE;
  end
  // datapath controls decoded from registered state and IR only
  always_comb begin
    bus.IRin    = state == FETCH;
    bus.Rin     = rin;
    bus.Rout    = rout;
    bus.Ain     = ex1 && cls.alu;
    bus.Gin     = state == EX2;
    bus.Gout    = state == EX3;
    bus.DINout  = ex1 && cls.imm;
    bus.OutEn   = ex1 && cls.outp;
    bus.Done    = (ex1 && !cls.alu && !(cls.illegal && TRAP)) || state == EX3;
    bus.Clear   = bus.Done;
    bus.Illegal = (ex1 && cls.illegal) || state == HALT;
    bus.AluOp   = ir[OP_MSB:OP_LSB];
    bus.DinData = {6'b0, ir[IMM_MSB:IMM_LSB]};
    bus.Step    = ex1 || state == HALT ? 2'd1 : state == EX2 ? 2'd2 : state == EX3 ? 2'd3 : 2'd0;
  end
endmodule
